// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave stream block.
// Holds the SPI mode encodings ({CPOL, CPHA}), the frame FSM state type
// and the default word width used by the top level.
package spi_pkg;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   localparam int DEFAULT_DATA_BITS = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;

   // Data is sampled on the rising SCK edge in modes 0 and 3, falling otherwise.
   function automatic logic sample_on_rise(input logic [1:0] mode);
      return (mode == SPI_MODE0) || (mode == SPI_MODE3);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with edge pulses.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   din          asynchronous input
//   dout         synchronised level (STAGES flops deep)
//   rise, fall   one-cycle pulses on edges of dout
// All flops reset to RESET_VAL so an idle line produces no edge at reset.
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RESET_VAL}};
         prev  <= RESET_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign dout = chain[STAGES-1];
   assign rise = dout & ~prev;
   assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave_stream.sv
// Full-duplex SPI slave feeding the LED frame-buffer writer.
// Ports:
//   clk, rst_n          system clock (>= 4x SCK), async active-low reset
//   sck, cs, mosi       asynchronous SPI pins (cs active low)
//   miso, miso_oe       slave data out and pad tristate enable
//   rx_data, rx_valid   last received word and its one-cycle strobe
//   tx_data, tx_valid,
//   tx_ready            holding-register load handshake for the next tx word
//   frame_active        high while a frame is in progress
//   frame_end           one-cycle pulse when cs deasserts
//   partial_word        sticky: frame ended mid-word
//   tx_underrun         sticky: a word started with no tx word held
//   word_count          complete words received in the current/last frame
//
// state  | meaning
// IDLE   | cs high or frame not yet armed; miso tristated
// ACTIVE | cs low; shifting rx/tx on SCK edges
module spi_slave_stream
   import spi_pkg::*;
#(
   parameter int DATA_BITS   = DEFAULT_DATA_BITS,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_BITS    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sck,
   input  logic                 cs,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 miso_oe,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 frame_active,
   output logic                 frame_end,
   output logic                 partial_word,
   output logic                 tx_underrun,
   output logic [CNT_BITS-1:0]  word_count
);

   if (DATA_BITS < 4 || DATA_BITS > 32) begin : g_bad_width
      $error("spi_slave_stream: DATA_BITS must be 4..32");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("spi_slave_stream: SYNC_STAGES must be at least 2");
   end

   localparam int         BC_W        = $clog2(DATA_BITS);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);
   localparam logic [1:0] MODE        = {CPOL != 0, CPHA != 0};
   localparam logic       SAMPLE_RISE = sample_on_rise(MODE);
   localparam logic       CPHA0       = (CPHA == 0);
   localparam int         FLUSH_W     = $clog2(SYNC_STAGES + 2);
   localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(SYNC_STAGES + 1);

   logic sck_level_unused, sck_rise, sck_fall;
   logic cs_s, cs_rise, cs_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL != 0)) u_sync_sck (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sck),
      .dout (sck_level_unused),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (cs),
      .dout (cs_s),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (mosi),
      .dout (mosi_s),
      .rise (mosi_rise_unused),
      .fall (mosi_fall_unused)
   );

   spi_state_t           state, state_next;
   logic                 start_frame, end_frame, sample, shift, last_sample;
   logic                 tx_load, accept;
   logic                 armed;
   logic [FLUSH_W-1:0]   flush_cnt;
   logic [BC_W-1:0]      bit_cnt;
   logic                 load_pending;
   logic [DATA_BITS-1:0] rx_shift, rx_next;
   logic [DATA_BITS-1:0] tx_shift, tx_advanced, tx_hold;
   logic                 hold_full;
   logic                 sample_edge, shift_edge;

   assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
   assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      sample      = 1'b0;
      shift       = 1'b0;
      unique case (state)
         IDLE: begin
            if (cs_fall && armed) begin
               state_next  = ACTIVE;
               start_frame = 1'b1;
            end
         end
         ACTIVE: begin
            // cs rise wins over any SCK edge detected in the same cycle
            if (cs_rise) begin
               state_next = IDLE;
               end_frame  = 1'b1;
            end else begin
               sample = sample_edge;
               shift  = shift_edge;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign last_sample = sample && (bit_cnt == LAST_BIT);
   // CPHA=0 drives bit 0 from the load at cs fall; every later word (and every
   // word in CPHA=1) is loaded by the first shift edge after the word starts.
   assign tx_load     = (start_frame && CPHA0) || (shift && load_pending);
   assign accept      = tx_valid && !hold_full;

   always_comb begin
      rx_next     = rx_shift;
      tx_advanced = tx_shift;
      if (MSB_FIRST != 0) begin
         rx_next     = {rx_shift[DATA_BITS-2:0], mosi_s};
         tx_advanced = {tx_shift[DATA_BITS-2:0], 1'b0};
      end else begin
         rx_next     = {mosi_s, rx_shift[DATA_BITS-1:1]};
         tx_advanced = {1'b0, tx_shift[DATA_BITS-1:1]};
      end
   end

   // The cs synchroniser resets to "high", so a pin already low at reset
   // release looks like a falling edge. Frames are only armed once the
   // flushed synchroniser has shown cs genuinely high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= FLUSH_INIT;
         armed     <= 1'b0;
      end else if (flush_cnt != '0) begin
         flush_cnt <= flush_cnt - FLUSH_W'(1);
      end else if (cs_s) begin
         armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt      <= '0;
         rx_shift     <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         word_count   <= '0;
         partial_word <= 1'b0;
         frame_end    <= 1'b0;
         load_pending <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_end <= end_frame;
         if (start_frame) begin
            bit_cnt      <= '0;
            word_count   <= '0;
            partial_word <= 1'b0;
            load_pending <= ~CPHA0;
         end
         if (end_frame) begin
            partial_word <= (bit_cnt != '0);
            bit_cnt      <= '0;
            load_pending <= 1'b0;
         end
         if (sample) begin
            rx_shift <= rx_next;
            if (last_sample) begin
               rx_data      <= rx_next;
               rx_valid     <= 1'b1;
               word_count   <= word_count + CNT_BITS'(1);
               bit_cnt      <= '0;
               load_pending <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + BC_W'(1);
            end
         end
         if (shift) load_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift    <= '0;
         tx_hold     <= '0;
         hold_full   <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         if (start_frame) tx_underrun <= 1'b0;
         if (tx_load) begin
            tx_shift <= hold_full ? tx_hold : '0;
            if (!hold_full) tx_underrun <= 1'b1;
         end else if (shift) begin
            tx_shift <= tx_advanced;
         end
         // A load and an accept in the same cycle: the load saw the old
         // (empty) holding state, the new word stays held.
         if (accept) begin
            tx_hold   <= tx_data;
            hold_full <= 1'b1;
         end else if (tx_load) begin
            hold_full <= 1'b0;
         end
      end
   end

   assign tx_ready     = ~hold_full;
   assign frame_active = (state == ACTIVE);
   assign miso_oe      = (state == ACTIVE);
   assign miso         = (state == ACTIVE) &&
                         ((MSB_FIRST != 0) ? tx_shift[DATA_BITS-1] : tx_shift[0]);

endmodule

// File: tb/tb_spi_slave_stream.sv
module tb_spi_slave_stream;

   localparam int SW_HP = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, sck, cs, mosi, tx_valid;
   logic [7:0] tx_data;
   wire        miso, miso_oe, rx_valid, tx_ready, frame_active, frame_end;
   wire        partial_word, tx_underrun;
   wire [7:0]  rx_data;
   wire [15:0] word_count;

   spi_slave_stream #(
      .DATA_BITS(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2), .CNT_BITS(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .frame_active(frame_active), .frame_end(frame_end),
      .partial_word(partial_word), .tx_underrun(tx_underrun), .word_count(word_count)
   );

   // Mode sweep: one 12-bit LSB-first instance per {CPOL, CPHA}
   logic [3:0]  sw_sck, sw_cs, sw_mosi, sw_tx_valid;
   logic [11:0] sw_tx_data;
   wire  [3:0]  sw_miso, sw_oe, sw_rxv, sw_txr, sw_fa, sw_fe, sw_pw, sw_tu;
   wire  [11:0] sw_rx [4];
   wire  [15:0] sw_wc [4];

   for (genvar g = 0; g < 4; g++) begin : g_sw
      spi_slave_stream #(
         .DATA_BITS(12), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(0), .SYNC_STAGES(2), .CNT_BITS(16)
      ) u_sw (
         .clk(clk), .rst_n(rst_n), .sck(sw_sck[g]), .cs(sw_cs[g]), .mosi(sw_mosi[g]),
         .miso(sw_miso[g]), .miso_oe(sw_oe[g]), .rx_data(sw_rx[g]), .rx_valid(sw_rxv[g]),
         .tx_data(sw_tx_data), .tx_valid(sw_tx_valid[g]), .tx_ready(sw_txr[g]),
         .frame_active(sw_fa[g]), .frame_end(sw_fe[g]),
         .partial_word(sw_pw[g]), .tx_underrun(sw_tu[g]), .word_count(sw_wc[g])
      );
   end

   int vectors = 0;
   int miscompares = 0;

   int         rx_cnt = 0, fe_cnt = 0, acc_cnt = 0;
   logic [7:0] rx_q[$];

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_q.push_back(rx_data);
         rx_cnt++;
      end
      if (frame_end) fe_cnt++;
      if (tx_valid && tx_ready) acc_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Mode 0, MSB first: data set at the shift (falling) edge, miso read just
   // before the sample (rising) edge.
   task automatic xfer_bit(input logic b, input int hp, output logic m);
      mosi = b;
      tick(hp);
      m   = miso;
      sck = 1'b1;
      tick(hp);
      sck = 1'b0;
   endtask

   task automatic xfer_word(input logic [7:0] d, input int hp, output logic [7:0] m);
      logic b;
      m = '0;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(d[i], hp, b);
         m[i] = b;
      end
   endtask

   task automatic frame_start(input int hp);
      cs = 1'b0;
      tick(hp);
   endtask

   task automatic frame_stop(input int hp);
      tick(hp);
      cs = 1'b1;
      tick(8);
   endtask

   task automatic tx_push(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   task automatic sw_frame(input int m, input logic [11:0] d,
                           output logic [11:0] mi, output logic stable);
      logic cpol, cpha;
      cpol   = (m >= 2);
      cpha   = (m % 2 == 1);
      stable = 1'b1;
      mi     = '0;
      sw_cs[m] = 1'b0;
      tick(SW_HP);
      for (int i = 0; i < 12; i++) begin
         if (!cpha) begin
            sw_mosi[m] = d[i];
            tick(SW_HP);
            mi[i]     = sw_miso[m];
            sw_sck[m] = ~cpol;
            tick(SW_HP - 1);
            if (sw_miso[m] !== mi[i]) stable = 1'b0;
            tick(1);
            sw_sck[m] = cpol;
         end else begin
            sw_sck[m]  = ~cpol;
            sw_mosi[m] = d[i];
            tick(SW_HP);
            mi[i]     = sw_miso[m];
            sw_sck[m] = cpol;
            tick(SW_HP - 1);
            if (sw_miso[m] !== mi[i]) stable = 1'b0;
            tick(1);
         end
      end
      tick(SW_HP);
      sw_cs[m] = 1'b1;
      tick(8);
   endtask

   initial begin
      logic [7:0]  m0, m1, mx;
      logic [11:0] swm;
      logic        st, b;
      int          n0, fe0, a0;

      rst_n = 1'b0;
      sck = 1'b0; cs = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      sw_sck = 4'b1100; sw_cs = 4'b1111; sw_mosi = '0; sw_tx_valid = '0; sw_tx_data = '0;
      tick(4);

      chk("rst_tx_ready",     tx_ready,     1);
      chk("rst_rx_valid",     rx_valid,     0);
      chk("rst_miso_oe",      miso_oe,      0);
      chk("rst_word_count",   word_count,   0);
      chk("rst_frame_active", frame_active, 0);
      rst_n = 1'b1;
      tick(8);

      // Two-word frame with both tx words supplied
      tx_push(8'h96);
      fe0 = fe_cnt;
      rx_q.delete();
      frame_start(4);
      chk("t1_frame_active", frame_active, 1);
      chk("t1_miso_oe",      miso_oe,      1);
      tx_push(8'h0F);
      xfer_word(8'hA5, 4, m0);
      xfer_word(8'h3C, 4, m1);
      frame_stop(4);
      chk("t1_rx_count",  rx_q.size(),   2);
      chk("t1_rx0",       rx_q[0],       8'hA5);
      chk("t1_rx1",       rx_q[1],       8'h3C);
      chk("t1_words",     word_count,    2);
      chk("t1_miso0",     m0,            8'h96);
      chk("t1_miso1",     m1,            8'h0F);
      chk("t1_frame_end", fe_cnt - fe0,  1);
      chk("t1_idle",      frame_active,  0);

      // All four SPI modes, 12-bit LSB first
      for (int m = 0; m < 4; m++) begin
         sw_tx_data     = 12'h5A3;
         sw_tx_valid[m] = 1'b1;
         tick(1);
         sw_tx_valid[m] = 1'b0;
         sw_frame(m, 12'hABC, swm, st);
         chk($sformatf("sw%0d_rx", m),     sw_rx[m], 12'hABC);
         chk($sformatf("sw%0d_words", m),  sw_wc[m], 1);
         chk($sformatf("sw%0d_miso", m),   swm,      12'h5A3);
         chk($sformatf("sw%0d_stable", m), st,       1);
      end

      // Frame cut after 5 of 8 bits, then a clean frame
      fe0 = fe_cnt;
      n0  = rx_cnt;
      frame_start(4);
      for (int i = 0; i < 5; i++) xfer_bit(1'b1, 4, b);
      frame_stop(4);
      chk("t3_no_rx",     rx_cnt,        n0);
      chk("t3_partial",   partial_word,  1);
      chk("t3_frame_end", fe_cnt - fe0,  1);
      chk("t3_words",     word_count,    0);
      frame_start(4);
      chk("t3_partial_clr", partial_word, 0);
      xfer_word(8'h11, 4, mx);
      frame_stop(4);
      chk("t3_rx",        rx_q[$],       8'h11);
      chk("t3_partial2",  partial_word,  0);
      chk("t3_words2",    word_count,    1);

      // No tx words supplied at all
      n0 = rx_cnt;
      frame_start(4);
      xfer_word(8'h5A, 4, m0);
      xfer_word(8'hC3, 4, m1);
      frame_stop(4);
      chk("t4_miso0",    m0,            0);
      chk("t4_miso1",    m1,            0);
      chk("t4_underrun", tx_underrun,   1);
      chk("t4_rx_count", rx_cnt - n0,   2);
      chk("t4_rx1",      rx_q[$],       8'hC3);
      chk("t4_words",    word_count,    2);

      // Reset mid-word with cs held low
      frame_start(4);
      for (int i = 0; i < 3; i++) xfer_bit(1'b1, 4, b);
      rst_n = 1'b0;
      tick(2);
      chk("t5_miso_oe",   miso_oe,      0);
      chk("t5_miso",      miso,         0);
      chk("t5_active",    frame_active, 0);
      chk("t5_tx_ready",  tx_ready,     1);
      chk("t5_words",     word_count,   0);
      chk("t5_underrun",  tx_underrun,  0);
      chk("t5_rx_data",   rx_data,      0);
      rst_n = 1'b1;
      n0 = rx_cnt;
      tick(4);
      for (int i = 0; i < 8; i++) xfer_bit(1'b1, 4, b);
      chk("t5_no_rx",     rx_cnt,       n0);
      chk("t5_no_frame",  frame_active, 0);
      cs = 1'b1;
      tick(8);
      frame_start(4);
      xfer_word(8'hFF, 4, mx);
      frame_stop(4);
      chk("t5_rx_count",  rx_cnt - n0,  1);
      chk("t5_rx",        rx_q[$],      8'hFF);

      // Back-to-back words at SCK = clk/4 with tx_valid held high
      n0 = rx_cnt;
      a0 = acc_cnt;
      tx_data  = 8'h77;
      tx_valid = 1'b1;
      tick(2);
      frame_start(2);
      xfer_word(8'h12, 2, mx);
      xfer_word(8'h34, 2, mx);
      xfer_word(8'h56, 2, mx);
      frame_stop(2);
      tx_valid = 1'b0;
      chk("t6_rx_count", rx_cnt - n0,           3);
      chk("t6_rx0",      rx_q[rx_q.size() - 3], 8'h12);
      chk("t6_rx1",      rx_q[rx_q.size() - 2], 8'h34);
      chk("t6_rx2",      rx_q[rx_q.size() - 1], 8'h56);
      chk("t6_accepts",  acc_cnt - a0,          5);
      chk("t6_underrun", tx_underrun,           0);
      chk("t6_words",    word_count,            3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_slave_stream.md
Name: spi_slave_stream

Overview:
- Full-duplex SPI slave for the LED-data link.
- Next generation of the byte-only shift-in receiver. Adds:
  - parametrised word width, SPI mode and bit order;
  - a per-word rx strobe instead of one result per chip-select frame;
  - a MISO transmit path with valid/ready loading;
  - frame status flags.
- Sits between the external SPI pins and the LED frame-buffer writer, all in the clk domain.

Parameters:
- DATA_BITS, 8: bits per SPI word, range 4..32.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first on both MOSI and MISO.
- SYNC_STAGES, 2: synchroniser depth for sck/cs/mosi, minimum 2.
- CNT_BITS, 16: width of word_count.

Ports:
- clk  in  1  system clock; must be at least 4x the SCK frequency.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock, asynchronous.
- cs  in  1  chip select, active low, asynchronous.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  tristate enable for the miso pad.
- rx_data  out  DATA_BITS  last complete received word.
- rx_valid  out  1  one-cycle strobe when rx_data updates.
- tx_data  in  DATA_BITS  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register is empty.
- frame_active  out  1  high while in ACTIVE.
- frame_end  out  1  one-cycle pulse when cs deasserts.
- partial_word  out  1  sticky per frame: cs rose mid-word.
- tx_underrun  out  1  sticky per frame: a word started with the holding register empty.
- word_count  out  CNT_BITS  complete words received this frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - all outputs 0, except tx_ready = 1;
  - FSM in IDLE, synchroniser registers loaded with idle levels (cs = 1, sck = CPOL).
- Synchronisation: sck, cs and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronised signals. Pin-to-action latency is SYNC_STAGES+1 cycles.
- Edge selection:
  - sample edge is rising when CPOL == CPHA, falling otherwise;
  - shift edge is the opposite edge.
- FSM IDLE:
  - miso = 0, miso_oe = 0.
  - On the cs falling edge go to ACTIVE, clear bit_cnt, word_count, partial_word and tx_underrun, and perform a tx load.
- FSM ACTIVE:
  - miso_oe = 1, miso = current tx shift-register output bit.
  - Sample edge: shift the synchronised mosi into rx_shift, in the direction set by MSB_FIRST.
  - When bit_cnt == DATA_BITS-1 at a sample edge, on the following cycle:
    - rx_data takes the completed word, rx_valid pulses for 1 cycle;
    - word_count increments and wraps at 2^CNT_BITS;
    - bit_cnt returns to 0.
  - Shift edge:
    - CPHA = 0: advance tx_shift, except on the shift edge after the last sample of a word, which performs a tx load.
    - CPHA = 1: the first shift edge of each word performs a tx load and drives bit 0; later shift edges advance tx_shift.
  - CPHA = 0 bit 0 is driven by the tx load at cs fall.
  - A sample edge and a shift edge never coincide; simultaneous sck edge and cs rise resolves as cs rise.
- tx handshake:
  - Holding register accepts a word when tx_valid && tx_ready; tx_ready then drops the next cycle.
  - A tx load moves the holding word into tx_shift and raises tx_ready.
  - If the holding register is empty at a tx load, tx_shift is loaded with all zeros and tx_underrun is set.
  - Load and accept in the same cycle: the load takes the old holding word and the new word is accepted.
- cs rising edge in ACTIVE:
  - return to IDLE and pulse frame_end for 1 cycle;
  - if bit_cnt != 0, discard the partial word (no rx_valid) and set partial_word;
  - word_count, partial_word and tx_underrun hold until the next cs fall;
  - the holding register is kept.
- Async reset mid-frame aborts immediately with no rx_valid. The next frame starts only on a fresh cs falling edge.
- cs already low when reset releases: no frame starts until cs goes high then low.

Decomposition:
- Shared package spi_pkg:
  - mode encoding constants SPI_MODE0..3 as {CPOL, CPHA};
  - FSM state typedef {IDLE, ACTIVE};
  - default DATA_BITS.
- One natural sub-module: spi_sync_edge.
  - Parametrised SYNC_STAGES synchroniser with rise/fall pulse outputs.
  - Instantiated for sck, cs and mosi; the mosi instance ignores its edge outputs.

Test Plan:
- Mode 0, 8-bit, MSB first, cs low, MOSI 0xA5 then 0x3C, tx preloaded 0x96 and 0x0F:
  - rx_valid twice with rx_data 0xA5, 0x3C; word_count = 2;
  - MISO bits match 0x96 then 0x0F;
  - frame_end pulses once.
- Sweep all four CPOL/CPHA modes with DATA_BITS = 12, MSB_FIRST = 0, word 0xABC: rx_data = 0xABC in every mode; MISO is stable across each sample edge.
- cs rises after 5 of 8 bits: no rx_valid, partial_word = 1, frame_end = 1. Next frame clears both flags and receives 0x11 cleanly.
- tx_valid never asserted during a 2-word frame: MISO all zeros, tx_underrun = 1, rx path unaffected.
- rst_n pulled low mid-word then released with cs held low: all outputs reset, miso_oe = 0. No rx_valid until a cs high-then-low sequence; the next frame receives 0xFF correctly.
- Back-to-back words at SCK = clk/4: no lost bits, and tx_ready re-asserts within 1 cycle of each word-boundary tx load.
